// File: rtl/bnn_dsram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN data-SRAM arbiter slice.
//   - Bit positions inside the 16-bit controller SRAM ctrl word.
//   - Read-owner tag carried through the read-return pipe.
//   - Arbiter ownership states (also visible on the debug port).
// ---------------------------------------------------------------------------
package bnn_pkg;

   // Controller ctrl word: [12:0] address, [13] read enable, [14] write enable.
   localparam int CTRL_ADDR_MSB = 12;
   localparam int CTRL_RE_BIT   = 13;
   localparam int CTRL_WE_BIT   = 14;

   // Width of the starvation counter; large enough for MAX_STARVE up to 15.
   localparam int STARVE_W      = 4;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOCK  = 2'd2
   } arb_state_e;

   // A ctrl word is a request when either enable bit is set.
   function automatic logic ctrl_is_req(input logic [15:0] ctrl);
      return ctrl[CTRL_RE_BIT] | ctrl[CTRL_WE_BIT];
   endfunction

endpackage

// File: rtl/bnn_dsram_arbiter_if.sv
// ---------------------------------------------------------------------------
// bnn_dsram_arbiter_if
// Bundles the three buses around the data-SRAM arbiter.
//   core side : core_ctrl, core_wdata -> core_stall, core_rdata, core_rvalid
//   host side : host_req, host_we, host_addr, host_wdata, host_lock
//               -> host_gnt, host_rdata, host_rvalid, lock_ack
//   SRAM side : sram_addr, sram_re, sram_we, sram_wdata <- sram_rdata
// Modports:
//   slave  : the arbiter itself
//   master : the environment (controller, host loader and SRAM model)
//
// Handshake semantics: a core request (re or we set in core_ctrl) is taken
// in any cycle where core_stall is 0, and the requester must hold it while
// core_stall is 1. A host beat is taken in any cycle where host_req and
// host_gnt are both 1; host_gnt is combinational and the host holds
// host_req/host_we/host_addr/host_wdata until it sees host_gnt. Read data
// comes back as a single-cycle rvalid pulse on the issuing side only.
// ---------------------------------------------------------------------------
interface bnn_dsram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);

   logic [15:0]       core_ctrl;
   logic [DATA_W-1:0] core_wdata;
   logic              core_stall;
   logic [DATA_W-1:0] core_rdata;
   logic              core_rvalid;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
   logic              host_lock;
   logic              lock_ack;

   logic [ADDR_W-1:0] sram_addr;
   logic              sram_re;
   logic              sram_we;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   modport slave (
      input  core_ctrl, core_wdata,
      input  host_req, host_we, host_addr, host_wdata, host_lock,
      input  sram_rdata,
      output core_stall, core_rdata, core_rvalid,
      output host_gnt, host_rdata, host_rvalid, lock_ack,
      output sram_addr, sram_re, sram_we, sram_wdata
   );

   modport master (
      output core_ctrl, core_wdata,
      output host_req, host_we, host_addr, host_wdata, host_lock,
      output sram_rdata,
      input  core_stall, core_rdata, core_rvalid,
      input  host_gnt, host_rdata, host_rvalid, lock_ack,
      input  sram_addr, sram_re, sram_we, sram_wdata
   );

endinterface

// File: rtl/bnn_dsram_arbiter_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// bnn_rd_tag_pipe
// Shift pipe of {valid, owner} tags that follows each granted SRAM read
// until its data is on sram_rdata. Stage 0 lines up with sram_re; the tail
// (stage DEPTH-1) lines up with the cycle sram_rdata is valid.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties pipe)
//   i_push_valid      a read is granted this cycle
//   i_push_owner      who issued that read
//   o_core_inflight   some stage holds a valid core read
//   o_tail_valid      tail stage holds a valid read
//   o_tail_owner      owner of the tail stage
// ---------------------------------------------------------------------------
module bnn_rd_tag_pipe
   import bnn_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_push_valid,
   input  owner_e i_push_owner,
   output logic   o_core_inflight,
   output logic   o_tail_valid,
   output owner_e o_tail_owner
);

   logic   r_valid [DEPTH];
   owner_e r_owner [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_owner[i] <= OWN_CORE;
         end
      end else begin
         r_valid[0] <= i_push_valid;
         r_owner[0] <= i_push_owner;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_owner[i] <= r_owner[i-1];
         end
      end
   end

   always_comb begin
      o_core_inflight = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_owner[i] == OWN_CORE)) begin
            o_core_inflight = 1'b1;
         end
      end
   end

   assign o_tail_valid = r_valid[DEPTH-1];
   assign o_tail_owner = r_owner[DEPTH-1];

endmodule

// File: rtl/bnn_dsram_arbiter.sv
// ---------------------------------------------------------------------------
// bnn_dsram_arbiter
// Shares the single-port data SRAM between the BNN instruction controller
// (core, priority) and the host weight/bias/image loader.
//   - Core wins by default; after MAX_STARVE consecutive denied host cycles
//     a pending host beat preempts the core for one cycle.
//   - host_lock walks RUN -> (DRAIN) -> LOCK; in LOCK the host owns the
//     SRAM and every core request stalls. DRAIN waits for in-flight core
//     reads to return before lock_ack rises.
//   - Reads are tagged with their owner so data returns only to the issuer,
//     RD_LAT+2 cycles after the grant, in issue order.
// Parameters: ADDR_W, DATA_W, RD_LAT (1..4), MAX_STARVE (1..15).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           core / host / SRAM buses (slave modport)
//   o_dbg_state   current ownership state
//   o_dbg_starve  current starvation count
// ---------------------------------------------------------------------------
module bnn_dsram_arbiter
   import bnn_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 16,
   parameter int RD_LAT     = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic                clk,
   input  logic                rst,
   bnn_dsram_arbiter_if.slave  bus,
   output arb_state_e          o_dbg_state,
   output logic [STARVE_W-1:0] o_dbg_starve
);

   // ---------------- request decode ----------------
   logic              w_core_req;
   logic              w_core_rd;
   logic              w_core_wr;
   logic [ADDR_W-1:0] w_core_addr;
   logic              w_unused_ctrl;

   // Write takes precedence when both enables are set; the read is dropped.
   assign w_core_req    = ctrl_is_req(bus.core_ctrl);
   assign w_core_wr     = bus.core_ctrl[CTRL_WE_BIT];
   assign w_core_rd     = bus.core_ctrl[CTRL_RE_BIT] & ~w_core_wr;
   assign w_core_addr   = ADDR_W'(bus.core_ctrl[CTRL_ADDR_MSB:0]);
   assign w_unused_ctrl = bus.core_ctrl[15];

   // ---------------- state / arbitration ----------------
   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic [STARVE_W-1:0] r_starve;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                w_starve_full;
   logic                w_core_win;
   logic                w_host_win;
   logic                w_core_inflight;
   logic                r_lock_ack;

   assign w_starve_full = (r_starve == STARVE_W'(MAX_STARVE));

   always_comb begin
      w_state_nxt = r_state;
      w_core_win  = 1'b0;
      w_host_win  = 1'b0;
      case (r_state)
         ST_RUN: begin
            // Core keeps priority unless the host has been starved long
            // enough and is still asking.
            if (w_core_req && !(w_starve_full && bus.host_req)) begin
               w_core_win = 1'b1;
            end else begin
               w_host_win = bus.host_req;
            end
            if (bus.host_lock) begin
               w_state_nxt = w_core_inflight ? ST_DRAIN : ST_LOCK;
            end
         end
         ST_DRAIN: begin
            // Nobody is granted while outstanding core reads return.
            if (!bus.host_lock) begin
               w_state_nxt = ST_RUN;
            end else if (!w_core_inflight) begin
               w_state_nxt = ST_LOCK;
            end
         end
         ST_LOCK: begin
            w_host_win = bus.host_req;
            if (!bus.host_lock) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Counts consecutive cycles where the host asks and is refused.
   always_comb begin
      w_starve_nxt = r_starve;
      if ((r_state == ST_LOCK) || !bus.host_req || w_host_win) begin
         w_starve_nxt = '0;
      end else if (!w_starve_full) begin
         w_starve_nxt = r_starve + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_starve   <= '0;
         r_lock_ack <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_starve   <= w_starve_nxt;
         // Tracks the state register, so it rises in the first LOCK cycle
         // and falls together with the return to RUN.
         r_lock_ack <= (w_state_nxt == ST_LOCK);
      end
   end

   // Grant/stall are combinational; hold them low while in reset so the
   // requesters never see a grant that the registers will discard.
   assign bus.host_gnt   = w_host_win & ~rst;
   assign bus.core_stall = w_core_req & ~w_core_win & ~rst;
   assign bus.lock_ack   = r_lock_ack;

   assign o_dbg_state  = r_state;
   assign o_dbg_starve = r_starve;

   // ---------------- SRAM command register ----------------
   logic              r_sram_re;
   logic              r_sram_we;
   logic [ADDR_W-1:0] r_sram_addr;
   logic [DATA_W-1:0] r_sram_wdata;

   // Address and write data only move on an access, so idle cycles keep
   // the last values on the SRAM pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sram_re    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
      end else begin
         r_sram_re <= 1'b0;
         r_sram_we <= 1'b0;
         if (w_core_win) begin
            r_sram_addr <= w_core_addr;
            r_sram_re   <= w_core_rd;
            r_sram_we   <= w_core_wr;
            if (w_core_wr) begin
               r_sram_wdata <= bus.core_wdata;
            end
         end else if (w_host_win) begin
            r_sram_addr <= bus.host_addr;
            r_sram_re   <= ~bus.host_we;
            r_sram_we   <= bus.host_we;
            if (bus.host_we) begin
               r_sram_wdata <= bus.host_wdata;
            end
         end
      end
   end

   assign bus.sram_re    = r_sram_re;
   assign bus.sram_we    = r_sram_we;
   assign bus.sram_addr  = r_sram_addr;
   assign bus.sram_wdata = r_sram_wdata;

   // ---------------- read return ----------------
   logic   w_push_valid;
   owner_e w_push_owner;
   logic   w_tail_valid;
   owner_e w_tail_owner;

   assign w_push_valid = (w_core_win & w_core_rd) | (w_host_win & ~bus.host_we);
   assign w_push_owner = w_host_win ? OWN_HOST : OWN_CORE;

   bnn_rd_tag_pipe #(
      .DEPTH (RD_LAT + 1)
   ) u_tag_pipe (
      .clk             (clk),
      .rst             (rst),
      .i_push_valid    (w_push_valid),
      .i_push_owner    (w_push_owner),
      .o_core_inflight (w_core_inflight),
      .o_tail_valid    (w_tail_valid),
      .o_tail_owner    (w_tail_owner)
   );

   logic              r_core_rvalid;
   logic              r_host_rvalid;
   logic [DATA_W-1:0] r_core_rdata;
   logic [DATA_W-1:0] r_host_rdata;

   // The tail tag is aligned with valid sram_rdata; steer it to the owner
   // and leave the other side's data untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_core_rvalid <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_core_rdata  <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_core_rvalid <= 1'b0;
         r_host_rvalid <= 1'b0;
         if (w_tail_valid) begin
            if (w_tail_owner == OWN_CORE) begin
               r_core_rvalid <= 1'b1;
               r_core_rdata  <= bus.sram_rdata;
            end else begin
               r_host_rvalid <= 1'b1;
               r_host_rdata  <= bus.sram_rdata;
            end
         end
      end
   end

   assign bus.core_rvalid = r_core_rvalid;
   assign bus.core_rdata  = r_core_rdata;
   assign bus.host_rvalid = r_host_rvalid;
   assign bus.host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_bnn_dsram_arbiter.sv
module tb_bnn_dsram_arbiter;
   import bnn_pkg::*;

   localparam int ADDR_W     = 13;
   localparam int DATA_W     = 16;
   localparam int RD_LAT     = 1;
   localparam int MAX_STARVE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arb_state_e    dbg_state;
   logic [3:0]    dbg_starve;
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [16:0]   exp_q[$];
   logic [16:0]   exp_item;

   bnn_dsram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bnn_dsram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LAT     (RD_LAT),
      .MAX_STARVE (MAX_STARVE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .o_dbg_state  (dbg_state),
      .o_dbg_starve (dbg_starve)
   );

   // ---------------- scoreboard ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change right after the falling edge; outputs are sampled 1ns later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_idle();
      bus.core_ctrl  = '0;
      bus.core_wdata = '0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
      bus.host_lock  = 1'b0;
      bus.sram_rdata = '0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         set_idle();
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_idle();
      rst = 1'b1;
      repeat (3) tick();
      #1;
      // ---- reset state ----
      check_eq("rst_sram_re",     bus.sram_re,     0);
      check_eq("rst_sram_we",     bus.sram_we,     0);
      check_eq("rst_sram_addr",   bus.sram_addr,   0);
      check_eq("rst_sram_wdata",  bus.sram_wdata,  0);
      check_eq("rst_core_rvalid", bus.core_rvalid, 0);
      check_eq("rst_host_rvalid", bus.host_rvalid, 0);
      check_eq("rst_lock_ack",    bus.lock_ack,    0);
      check_eq("rst_core_stall",  bus.core_stall,  0);
      check_eq("rst_host_gnt",    bus.host_gnt,    0);
      check_eq("rst_state",       dbg_state,       ST_RUN);
      check_eq("rst_starve",      dbg_starve,      0);
      tick();
      rst = 1'b0;
      idle_cycles(2);

      // ---- core read 0x0123 ----
      tick();
      bus.core_ctrl = 16'h2123;
      #1;
      check_eq("rd_stall", bus.core_stall, 0);
      check_eq("rd_hgnt",  bus.host_gnt,   0);
      tick();
      bus.core_ctrl = '0;
      #1;
      check_eq("rd_sram_re",   bus.sram_re,   1);
      check_eq("rd_sram_we",   bus.sram_we,   0);
      check_eq("rd_sram_addr", bus.sram_addr, 16'h0123);
      tick();
      bus.sram_rdata = 16'hBEEF;
      #1;
      check_eq("rd_re_idle",  bus.sram_re,     0);
      check_eq("rd_early_rv", bus.core_rvalid, 0);
      tick();
      bus.sram_rdata = '0;
      #1;
      check_eq("rd_core_rv",   bus.core_rvalid, 1);
      check_eq("rd_core_data", bus.core_rdata,  16'hBEEF);
      check_eq("rd_host_rv",   bus.host_rvalid, 0);
      tick();
      #1;
      check_eq("rd_rv_pulse", bus.core_rvalid, 0);
      idle_cycles(3);

      // ---- starvation: host gets every 5th cycle ----
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 1) begin
            bus.core_ctrl  = 16'h2044;
            bus.host_req   = 1'b1;
            bus.host_we    = 1'b1;
            bus.host_addr  = 13'h00AA;
            bus.host_wdata = 16'h7777;
         end
         #1;
         check_eq($sformatf("starve_gnt%0d", i),   bus.host_gnt,   (i % 5 == 0));
         check_eq($sformatf("starve_stall%0d", i), bus.core_stall, (i % 5 == 0));
         check_eq($sformatf("starve_cnt%0d", i),   dbg_starve,     (i - 1) % 5);
      end
      tick();
      set_idle();
      #1;
      check_eq("starve_sram_we",   bus.sram_we,   1);
      check_eq("starve_sram_addr", bus.sram_addr, 16'h00AA);
      idle_cycles(4);

      // ---- simultaneous writes: core then host ----
      tick();
      bus.core_ctrl  = 16'h4010;
      bus.core_wdata = 16'h5A5A;
      bus.host_req   = 1'b1;
      bus.host_we    = 1'b1;
      bus.host_addr  = 13'h0020;
      bus.host_wdata = 16'h1111;
      #1;
      check_eq("wr_core_stall", bus.core_stall, 0);
      check_eq("wr_host_gnt0",  bus.host_gnt,   0);
      tick();
      bus.core_ctrl = '0;
      #1;
      check_eq("wr_host_gnt1", bus.host_gnt,   1);
      check_eq("wr1_we",       bus.sram_we,    1);
      check_eq("wr1_addr",     bus.sram_addr,  16'h0010);
      check_eq("wr1_data",     bus.sram_wdata, 16'h5A5A);
      tick();
      bus.host_req = 1'b0;
      #1;
      check_eq("wr2_we",   bus.sram_we,    1);
      check_eq("wr2_addr", bus.sram_addr,  16'h0020);
      check_eq("wr2_data", bus.sram_wdata, 16'h1111);
      tick();
      #1;
      check_eq("wr_idle_we",   bus.sram_we,    0);
      check_eq("wr_idle_addr", bus.sram_addr,  16'h0020);
      check_eq("wr_idle_data", bus.sram_wdata, 16'h1111);
      idle_cycles(2);

      // ---- lock with a core read in flight ----
      tick();
      bus.core_ctrl = 16'h2055;
      #1;
      check_eq("lk_rd_stall", bus.core_stall, 0);
      tick();
      bus.core_ctrl = '0;
      bus.host_lock = 1'b1;
      #1;
      check_eq("lk_sram_re", bus.sram_re, 1);
      check_eq("lk_state0",  dbg_state,   ST_RUN);
      tick();
      bus.sram_rdata = 16'hCAFE;
      bus.core_ctrl  = 16'h2077;
      #1;
      check_eq("lk_state_drain", dbg_state,      ST_DRAIN);
      check_eq("lk_drain_stall", bus.core_stall, 1);
      tick();
      bus.sram_rdata = '0;
      bus.core_ctrl  = '0;
      #1;
      check_eq("lk_core_rv",   bus.core_rvalid, 1);
      check_eq("lk_core_data", bus.core_rdata,  16'hCAFE);
      check_eq("lk_ack_early", bus.lock_ack,    0);
      tick();
      #1;
      check_eq("lk_ack",   bus.lock_ack, 1);
      check_eq("lk_state", dbg_state,    ST_LOCK);
      for (int k = 0; k < 8; k++) begin
         tick();
         bus.host_req   = 1'b1;
         bus.host_we    = 1'b1;
         bus.host_addr  = 13'(32'h100 + k);
         bus.host_wdata = 16'(32'hA000 + k);
         bus.core_ctrl  = 16'(32'h2000 + k);
         #1;
         check_eq($sformatf("lk_gnt%0d", k),   bus.host_gnt,   1);
         check_eq($sformatf("lk_stall%0d", k), bus.core_stall, 1);
         if (k > 0) begin
            check_eq($sformatf("lk_addr%0d", k), bus.sram_addr, 32'h100 + k - 1);
         end
      end
      tick();
      bus.host_req  = 1'b0;
      bus.host_lock = 1'b0;
      bus.core_ctrl = 16'h2000;
      #1;
      check_eq("lk_last_we",   bus.sram_we,    1);
      check_eq("lk_last_addr", bus.sram_addr,  16'h0107);
      check_eq("lk_last_data", bus.sram_wdata, 16'hA007);
      check_eq("lk_hold_ack",  bus.lock_ack,   1);
      check_eq("lk_hold_stall", bus.core_stall, 1);
      tick();
      #1;
      check_eq("unlk_ack",   bus.lock_ack,   0);
      check_eq("unlk_state", dbg_state,      ST_RUN);
      check_eq("unlk_stall", bus.core_stall, 0);
      tick();
      bus.core_ctrl = '0;
      #1;
      check_eq("unlk_sram_re", bus.sram_re, 1);
      idle_cycles(4);

      // ---- interleaved reads: core A, host B, core C ----
      tick();
      bus.core_ctrl = 16'h20A0;
      exp_q.push_back({1'b0, 16'h1A1A});
      #1;
      check_eq("il_a_stall", bus.core_stall, 0);
      tick();
      bus.core_ctrl = '0;
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 13'h00B0;
      exp_q.push_back({1'b1, 16'h2B2B});
      #1;
      check_eq("il_b_gnt",  bus.host_gnt,  1);
      check_eq("il_a_addr", bus.sram_addr, 16'h00A0);
      tick();
      bus.host_req   = 1'b0;
      bus.core_ctrl  = 16'h20C0;
      bus.sram_rdata = 16'h1A1A;
      exp_q.push_back({1'b0, 16'h3C3C});
      #1;
      check_eq("il_c_stall", bus.core_stall, 0);
      check_eq("il_b_addr",  bus.sram_addr,  16'h00B0);
      tick();
      bus.core_ctrl  = '0;
      bus.sram_rdata = 16'h2B2B;
      #1;
      check_eq("il_c_addr", bus.sram_addr, 16'h00C0);
      for (int r = 0; r < 3; r++) begin
         if (r > 0) begin
            tick();
            bus.sram_rdata = (r == 1) ? 16'h3C3C : 16'h0000;
            #1;
         end
         exp_item = exp_q.pop_front();
         check_eq($sformatf("il_core_rv%0d", r), bus.core_rvalid, !exp_item[16]);
         check_eq($sformatf("il_host_rv%0d", r), bus.host_rvalid, exp_item[16]);
         if (exp_item[16]) begin
            check_eq($sformatf("il_host_data%0d", r), bus.host_rdata, exp_item[15:0]);
         end else begin
            check_eq($sformatf("il_core_data%0d", r), bus.core_rdata, exp_item[15:0]);
         end
      end
      check_eq("il_host_hold", bus.host_rdata, 16'h2B2B);
      idle_cycles(3);

      // ---- reset during an outstanding host read ----
      tick();
      bus.host_req  = 1'b1;
      bus.host_we   = 1'b0;
      bus.host_addr = 13'h0033;
      #1;
      check_eq("rr_gnt", bus.host_gnt, 1);
      tick();
      rst = 1'b1;
      #1;
      check_eq("rr_sram_re",   bus.sram_re,    0);
      check_eq("rr_sram_addr", bus.sram_addr,  0);
      check_eq("rr_host_gnt",  bus.host_gnt,   0);
      check_eq("rr_host_data", bus.host_rdata, 0);
      check_eq("rr_core_data", bus.core_rdata, 0);
      bus.host_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         check_eq($sformatf("rr_no_rv%0d", i), bus.host_rvalid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
